// File: rtl/soc_timer_axil_regs_pkg.sv
// Register map, response codes and field layout shared by the SoC timer
// AXI4-Lite register front end.
package soc_timer_axil_regs_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam logic [7:0] REG_LOAD_OFF       = 8'h00;
    localparam logic [7:0] REG_CONTROL_OFF    = 8'h04;
    localparam logic [7:0] REG_COUNTER_OFF    = 8'h08;
    localparam logic [7:0] REG_INT_STATUS_OFF = 8'h0C;
    localparam logic [7:0] REG_INT_CLEAR_OFF  = 8'h10;

    // Word indices as seen by the decoder (address bits [7:2]).
    localparam logic [5:0] IDX_LOAD       = REG_LOAD_OFF[7:2];
    localparam logic [5:0] IDX_CONTROL    = REG_CONTROL_OFF[7:2];
    localparam logic [5:0] IDX_COUNTER    = REG_COUNTER_OFF[7:2];
    localparam logic [5:0] IDX_INT_STATUS = REG_INT_STATUS_OFF[7:2];
    localparam logic [5:0] IDX_INT_CLEAR  = REG_INT_CLEAR_OFF[7:2];

    localparam int INT_CLEAR_BIT  = 0;
    localparam int INT_STATUS_BIT = 0;

    typedef struct packed {
        logic irq_mask;
        logic auto_reload;
        logic enable;
    } soc_timer_ctrl_t;

    localparam int          CTRL_W          = $bits(soc_timer_ctrl_t);
    localparam logic [31:0] CTRL_FIELD_MASK = 32'h7;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/soc_timer_axil_regs.sv
// AXI4-Lite slave for the SoC timer: holds LOAD/CONTROL, emits load and
// interrupt-clear pulses, and returns counter/interrupt status on reads.
module soc_timer_axil_regs
    import soc_timer_axil_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [31:0]           s_axil_wdata,
    input  logic [3:0]            s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [31:0]           s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [31:0]           load_value,
    output logic                  load_strobe,
    output logic                  ctrl_enable,
    output logic                  ctrl_auto_reload,
    output logic                  ctrl_irq_mask,
    output logic                  irq_clear,
    input  logic [31:0]           counter_value,
    input  logic                  irq_flag
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("soc_timer_axil_regs: DATA_WIDTH must be 32");
        end
    endgenerate

    wr_state_t       wr_state;
    rd_state_t       rd_state;
    logic [5:0]      aw_idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    soc_timer_ctrl_t ctrl_q;

    logic            aw_hs;
    logic            w_hs;
    logic            ar_hs;
    logic            wr_commit;
    logic [5:0]      cmt_idx;
    logic [31:0]     cmt_data;
    logic [3:0]      cmt_strb;
    logic [31:0]     rd_data_next;
    logic [1:0]      rd_resp_next;

    // Only address bits [7:2] take part in decoding; the map aliases every 256 bytes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_awaddr[1:0],
                                s_axil_araddr[ADDR_WIDTH-1:8], s_axil_araddr[1:0]};

    assign s_axil_awready = !rst && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
    assign s_axil_wready  = !rst && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
    assign s_axil_arready = !rst && (rd_state == RD_IDLE);

    assign aw_hs = s_axil_awvalid && s_axil_awready;
    assign w_hs  = s_axil_wvalid && s_axil_wready;
    assign ar_hs = s_axil_arvalid && s_axil_arready;

    assign wr_commit = (wr_state == WR_IDLE    && aw_hs && w_hs) ||
                       (wr_state == WR_HAVE_AW && w_hs) ||
                       (wr_state == WR_HAVE_W  && aw_hs);

    assign ctrl_enable      = ctrl_q.enable;
    assign ctrl_auto_reload = ctrl_q.auto_reload;
    assign ctrl_irq_mask    = ctrl_q.irq_mask;

    // Whichever half arrives on the commit edge comes straight from the bus.
    always_comb begin
        cmt_idx  = aw_idx_q;
        cmt_data = wdata_q;
        cmt_strb = wstrb_q;
        if (wr_state == WR_IDLE || wr_state == WR_HAVE_W) begin
            cmt_idx = s_axil_awaddr[7:2];
        end
        if (wr_state == WR_IDLE || wr_state == WR_HAVE_AW) begin
            cmt_data = s_axil_wdata;
            cmt_strb = s_axil_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state      <= WR_IDLE;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= AXI_RESP_OKAY;
            load_value    <= '0;
            ctrl_q        <= '0;
            load_strobe   <= 1'b0;
            irq_clear     <= 1'b0;
        end else begin
            load_strobe <= 1'b0;
            irq_clear   <= 1'b0;
            if (wr_commit) begin
                wr_state      <= WR_RESP;
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= AXI_RESP_OKAY;
                case (cmt_idx)
                    IDX_LOAD: begin
                        for (int b = 0; b < 4; b++) begin
                            if (cmt_strb[b]) begin
                                load_value[8*b +: 8] <= cmt_data[8*b +: 8];
                            end
                        end
                        load_strobe <= |cmt_strb;
                    end
                    IDX_CONTROL: begin
                        if (cmt_strb[0]) begin
                            ctrl_q <= soc_timer_ctrl_t'(cmt_data[CTRL_W-1:0]);
                        end
                    end
                    IDX_INT_CLEAR: begin
                        irq_clear <= cmt_strb[0] && cmt_data[INT_CLEAR_BIT];
                    end
                    default: begin
                        s_axil_bresp <= AXI_RESP_SLVERR;
                    end
                endcase
            end else begin
                case (wr_state)
                    WR_IDLE: begin
                        if (aw_hs) begin
                            aw_idx_q <= s_axil_awaddr[7:2];
                            wr_state <= WR_HAVE_AW;
                        end else if (w_hs) begin
                            wdata_q  <= s_axil_wdata;
                            wstrb_q  <= s_axil_wstrb;
                            wr_state <= WR_HAVE_W;
                        end
                    end
                    WR_RESP: begin
                        if (s_axil_bready) begin
                            s_axil_bvalid <= 1'b0;
                            wr_state      <= WR_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Read data is taken from the registers as they stand before any same-edge write.
    always_comb begin
        rd_data_next = '0;
        rd_resp_next = AXI_RESP_OKAY;
        case (s_axil_araddr[7:2])
            IDX_CONTROL:    rd_data_next = {{(32-CTRL_W){1'b0}}, ctrl_q} & CTRL_FIELD_MASK;
            IDX_COUNTER:    rd_data_next = counter_value;
            IDX_INT_STATUS: rd_data_next[INT_STATUS_BIT] = irq_flag;
            default:        rd_resp_next = AXI_RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state      <= RD_IDLE;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= AXI_RESP_OKAY;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        s_axil_rdata  <= rd_data_next;
                        s_axil_rresp  <= rd_resp_next;
                        s_axil_rvalid <= 1'b1;
                        rd_state      <= RD_RESP;
                    end
                end
                default: begin
                    if (s_axil_rready) begin
                        s_axil_rvalid <= 1'b0;
                        rd_state      <= RD_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_timer_axil_regs.sv
// Directed plus randomized bench for the timer AXI4-Lite register front end,
// checked against a register-map level model.
module tb_soc_timer_axil_regs;

    logic        clk;
    logic        rst;
    logic [31:0] awaddr, wdata, araddr, rdata, load_value, counter_value;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        load_strobe, ctrl_enable, ctrl_auto_reload, ctrl_irq_mask, irq_clear, irq_flag;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_load;
    logic [2:0]  m_ctrl;

    soc_timer_axil_regs dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .load_value(load_value), .load_strobe(load_strobe),
        .ctrl_enable(ctrl_enable), .ctrl_auto_reload(ctrl_auto_reload), .ctrl_irq_mask(ctrl_irq_mask),
        .irq_clear(irq_clear), .counter_value(counter_value), .irq_flag(irq_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        bad++;
        $error("FAIL %s: observed=timeout expected=handshake", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctrl_now();
        return {29'b0, ctrl_irq_mask, ctrl_auto_reload, ctrl_enable};
    endfunction

    // Register-map semantics: word index is address bits [7:2].
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic exp_ls, output logic exp_ic, output logic [1:0] exp_resp);
        int idx;
        idx = (addr >> 2) % 64;
        exp_ls = 1'b0;
        exp_ic = 1'b0;
        exp_resp = 2'b00;
        if (idx == 0) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_load = (m_load & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
            exp_ls = (strb != 0);
        end else if (idx == 1) begin
            if (strb[0]) m_ctrl = data[2:0];
        end else if (idx == 4) begin
            exp_ic = strb[0] && data[0];
        end else begin
            exp_resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] exp_d, output logic [1:0] exp_r);
        int idx;
        idx = (addr >> 2) % 64;
        exp_r = 2'b00;
        case (idx)
            1:       exp_d = {29'b0, m_ctrl};
            2:       exp_d = counter_value;
            3:       exp_d = {31'b0, irq_flag};
            default: begin exp_d = 32'h0; exp_r = 2'b10; end
        endcase
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done = 0;
        int cyc = 0;
        logic hs_aw, hs_w, exp_ls, exp_ic;
        logic [1:0] exp_resp;
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (!w_done && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1; awaddr = $urandom; end
            if (hs_w)  begin wvalid = 1'b0; w_done = 1; wdata = $urandom; wstrb = 4'($urandom); end
            cyc++;
            if (cyc > 60) begin
                awvalid = 1'b0;
                wvalid = 1'b0;
                timeout("write_handshake");
                return;
            end
        end
        model_write(addr, data, strb, exp_ls, exp_ic, exp_resp);
        chk("bvalid_rise", 32'(bvalid), 1);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("load_strobe_pulse", 32'(load_strobe), 32'(exp_ls));
        chk("irq_clear_pulse", 32'(irq_clear), 32'(exp_ic));
        chk("load_value", load_value, m_load);
        chk("ctrl", ctrl_now(), {29'b0, m_ctrl});
        for (int i = 0; i < b_dly; i++) begin
            tick();
            chk("bvalid_hold", 32'(bvalid), 1);
            chk("bresp_hold", 32'(bresp), 32'(exp_resp));
            chk("pulses_single", {30'b0, load_strobe, irq_clear}, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_drop", 32'(bvalid), 0);
        chk("pulses_gone", {30'b0, load_strobe, irq_clear}, 0);
        chk("ready_after_b", {30'b0, awready, wready}, 3);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_dly);
        int n = 0;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        araddr = addr;
        arvalid = 1'b1;
        while (!arready) begin
            tick();
            n++;
            if (n > 60) begin
                arvalid = 1'b0;
                timeout("read_handshake");
                return;
            end
        end
        model_read(addr, exp_d, exp_r);
        tick();
        arvalid = 1'b0;
        araddr = $urandom;
        chk("rvalid_rise", 32'(rvalid), 1);
        chk("rdata", rdata, exp_d);
        chk("rresp", 32'(rresp), 32'(exp_r));
        for (int i = 0; i < r_dly; i++) begin
            counter_value = $urandom;
            irq_flag = 1'($urandom);
            tick();
            chk("rvalid_hold", 32'(rvalid), 1);
            chk("rdata_hold", rdata, exp_d);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_drop", 32'(rvalid), 0);
        chk("arready_after_r", 32'(arready), 1);
    endtask

    initial begin
        logic [31:0] offs [8];
        logic [31:0] a, d, old_ctrl;
        logic ls, ic;
        logic [1:0] rs;
        offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h40};

        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0; counter_value = '0; irq_flag = 1'b0;
        m_load = '0;
        m_ctrl = '0;
        tick();
        tick();
        chk("rst_readies", {29'b0, awready, wready, arready}, 0);
        chk("rst_valids", {30'b0, bvalid, rvalid}, 0);
        chk("rst_load_value", load_value, 0);
        chk("rst_ctrl", ctrl_now(), 0);
        chk("rst_pulses", {30'b0, load_strobe, irq_clear}, 0);
        rst = 1'b0;
        tick();
        chk("idle_readies", {29'b0, awready, wready, arready}, 7);

        // AW first, W three cycles later
        axi_write(32'h00, 32'hDEADBEEF, 4'hF, 0, 3, 0);
        chk("load_deadbeef", load_value, 32'hDEADBEEF);
        // W first, then AW
        axi_write(32'h04, 32'h5, 4'h1, 2, 0, 1);
        chk("ctrl_5", ctrl_now(), 32'h5);
        axi_read(32'h04, 0);
        // Partial byte-strobe update
        axi_write(32'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        axi_write(32'h00, 32'h11223344, 4'h3, 1, 1, 0);
        chk("load_partial", load_value, 32'hFFFF3344);
        // Counter snapshot held while rready is low
        counter_value = 32'h1234;
        axi_read(32'h08, 4);
        irq_flag = 1'b1;
        axi_read(32'h0C, 1);
        // Interrupt clear pulse only when bit 0 set
        axi_write(32'h10, 32'h1, 4'hF, 0, 0, 0);
        axi_write(32'h10, 32'h0, 4'hF, 0, 0, 0);
        // Read-only and unmapped accesses
        axi_write(32'h08, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        axi_read(32'h00, 0);
        axi_read(32'h1C, 0);
        chk("no_change_load", load_value, 32'hFFFF3344);

        // CONTROL read on the same edge as a CONTROL write commit sees the old value
        old_ctrl = {29'b0, m_ctrl};
        awaddr = 32'h04; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model_write(32'h04, 32'h2, 4'h1, ls, ic, rs);
        chk("same_edge_rvalid", {30'b0, bvalid, rvalid}, 3);
        chk("same_edge_old_ctrl", rdata, old_ctrl);
        chk("same_edge_new_ctrl", ctrl_now(), {29'b0, m_ctrl});
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("same_edge_done", {30'b0, bvalid, rvalid}, 0);

        // Randomized traffic, including address aliasing above bit 7 and in bits [1:0]
        for (int it = 0; it < 60; it++) begin
            a = ($urandom & 32'hFFFFFF00) | offs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                axi_write(a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                counter_value = $urandom;
                irq_flag = 1'($urandom);
                axi_read(a, $urandom_range(0, 3));
            end
        end

        // Reset with write and read responses pending
        axi_write(32'h04, 32'h7, 4'h1, 0, 0, 0);
        awaddr = 32'h00; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("pre_rst_pending", {30'b0, bvalid, rvalid}, 3);
        rst = 1'b1;
        tick();
        m_load = '0;
        m_ctrl = '0;
        chk("rst_drop_valids", {30'b0, bvalid, rvalid}, 0);
        chk("rst_drop_readies", {29'b0, awready, wready, arready}, 0);
        chk("rst_clear_load", load_value, m_load);
        chk("rst_clear_ctrl", ctrl_now(), {29'b0, m_ctrl});
        chk("rst_clear_rdata", rdata, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_readies", {29'b0, awready, wready, arready}, 7);
        axi_read(32'h04, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_timer_axil_regs.md
Name: soc_timer_axil_regs

Overview:
AXI4-Lite slave front end for the SoC timer. It sits between the interconnect and the timer counter core. It decodes bus writes into load/control/clear actions and returns counter and interrupt status on reads. It holds the architectural CONTROL and LOAD registers; the counter core consumes its outputs.

Parameters:
ADDR_WIDTH, 32, width of s_axil_awaddr/araddr. Only bits [7:2] are decoded; bits [1:0] and bits above 7 are ignored, so the map aliases every 256 bytes.
DATA_WIDTH, 32, bus data width. Fixed at 32; elaboration error otherwise.

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
s_axil_awaddr  in  ADDR_WIDTH  write address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address ready
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  write byte strobes
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data ready
s_axil_bresp  out  2  write response
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  write response ready
s_axil_araddr  in  ADDR_WIDTH  read address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address ready
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  read response
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  read data ready
load_value  out  32  LOAD register contents
load_strobe  out  1  one-cycle pulse after any write to LOAD
ctrl_enable  out  1  CONTROL bit 0
ctrl_auto_reload  out  1  CONTROL bit 1
ctrl_irq_mask  out  1  CONTROL bit 2
irq_clear  out  1  one-cycle pulse: INT_CLEAR written with bit 0 = 1
counter_value  in  32  live counter from the timer core
irq_flag  in  1  interrupt flag from the timer core

Behaviour:
- Reset values: all outputs are 0. Readies are held low while rst = 1.
- Reset mid-transaction drops any latched AW/W/AR and any pending response. BVALID and RVALID are 0 at the next edge.

Write channel FSM (WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP):
- awready = 1 in WR_IDLE or WR_HAVE_W.
- wready = 1 in WR_IDLE or WR_HAVE_AW.
- AW and W may arrive in either order or in the same cycle. Each is latched on its handshake.
- When both are held, the register update occurs on that edge, the FSM enters WR_RESP, and bvalid = 1 in the following cycle.
- bvalid and bresp stay stable until bready is seen. On B handshake the FSM returns to WR_IDLE, so readies are high the next cycle.
- Throughput is one write per 2 cycles minimum.
- LOAD (0x00): bytes are updated per wstrb. load_strobe pulses in the cycle bvalid rises if wstrb != 0. Response OKAY.
- CONTROL (0x04): bits [2:0] are updated if wstrb[0]. Upper bits are ignored. Response OKAY.
- INT_CLEAR (0x10): irq_clear pulses in the cycle bvalid rises if wstrb[0] && wdata[0]. Response OKAY.
- COUNTER (0x08) and INT_STATUS (0x0C) are read-only: no state change, SLVERR (2'b10).
- Unmapped offsets: no state change, SLVERR.

Read channel FSM (RD_IDLE, RD_RESP):
- arready = 1 in RD_IDLE.
- On AR handshake, rdata and rresp are captured from the current register/input values. rvalid = 1 the next cycle (latency 1).
- rdata and rresp are held until rready is seen, then the FSM returns to RD_IDLE.
- CONTROL reads {29'b0, mask, reload, enable}.
- COUNTER reads counter_value as sampled at the AR handshake.
- INT_STATUS reads {31'b0, irq_flag}.
- LOAD, INT_CLEAR and unmapped offsets read 0 with SLVERR.

Channel interaction:
- Read and write channels are independent and may complete in the same cycle.
- A CONTROL read handshaking in the same cycle as the CONTROL write-commit edge returns the old value.

Decomposition:
- The timer register package gains:
  - AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10;
  - a packed struct soc_timer_ctrl_t {irq_mask, auto_reload, enable};
  - CTRL_FIELD_MASK = 32'h7.
- Offsets and bit positions are taken from that package only.
- No sub-module is needed. The two FSMs stay in one flat module.

Test Plan:
- AW then W 3 cycles later, addr 0x00, data 0xDEADBEEF, wstrb 4'hF -> bvalid one cycle after the W handshake, bresp OKAY, load_value 0xDEADBEEF, one load_strobe pulse.
- W before AW, addr 0x04, data 0x5, wstrb 4'h1 -> enable = 1, reload = 0, mask = 1. A following read of 0x04 returns 0x00000005 with OKAY.
- Write 0x00 data 0x11223344 wstrb 4'h3, after LOAD = 0xFFFFFFFF -> load_value 0xFFFF3344.
- Read 0x08 with counter_value = 0x1234 at AR handshake; hold rready low 4 cycles while the counter changes -> rdata stays 0x00001234 and rvalid stays high.
- Write 0x10 data 0x1 -> irq_clear high exactly one cycle. Write 0x10 data 0x0 -> no pulse.
- Write 0x08, read 0x00, read 0x1C -> all SLVERR with read data 0, no output change. Assert rst with bvalid pending -> bvalid = 0 next cycle and all outputs return to 0.
